// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine:
// controller state encoding and index-width helpers.
package matmul_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;

    // Width needed to index n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate. acc presents the running sum
// including the current product, so the caller can store it directly.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              acc_clr,
    input  logic              en,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;

    assign prod  = a * b;
    assign acc_d = acc_q + ACC_W'(prod);
    assign acc   = acc_d;

    // Clear wins over accumulate so the last term of a dot product
    // can be stored and the register zeroed on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// C = A x B over unsigned operands, one MAC per cycle, with
// register-file style operand loading and a registered C read port.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int M      = 3,
    parameter int K      = 3,
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(K) + 1,
    localparam int AW    = idx_w(max2(M*K, K*N)),
    localparam int RW    = idx_w(M*N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [RW-1:0]     rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              complete,
    output logic              wr_err
);

    localparam int IW = idx_w(M);
    localparam int KW = idx_w(K);
    localparam int JW = idx_w(N);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic              complete_q, complete_d;
    logic              wr_err_q, wr_err_d;
    logic [ACC_W-1:0]  rd_q, rd_d;

    logic [DATA_W-1:0] a_q [M][K];
    logic [DATA_W-1:0] b_q [K][N];
    logic [ACC_W-1:0]  c_q [M][N];

    logic idle, comp;
    logic last_i, last_j, last_k;
    logic a_hit, b_hit, a_we, b_we, c_we;
    logic mac_clr;
    logic [ACC_W-1:0] mac_acc;

    assign idle   = (state_q == S_IDLE);
    assign comp   = (state_q == S_COMPUTE);
    assign last_i = (i_q == IW'(M-1));
    assign last_j = (j_q == JW'(N-1));
    assign last_k = (k_q == KW'(K-1));

    assign a_we     = wr_en & idle & ~wr_sel & a_hit;
    assign b_we     = wr_en & idle &  wr_sel & b_hit;
    assign wr_err_d = wr_en & ~(a_we | b_we);
    assign c_we     = comp & last_k;
    assign mac_clr  = (idle & start) | c_we;

    assign busy     = ~idle;
    assign done     = (state_q == S_FINISH);
    assign complete = complete_q;
    assign wr_err   = wr_err_q;
    assign rd_data  = rd_q;

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .a       (a_q[i_q][k_q]),
        .b       (b_q[k_q][j_q]),
        .acc_clr (mac_clr),
        .en      (comp),
        .acc     (mac_acc)
    );

    // Decode which operand addresses are in range.
    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++)
                a_hit = a_hit | (wr_addr == AW'(r*K + c));
        for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++)
                b_hit = b_hit | (wr_addr == AW'(r*N + c));
    end

    // Select the C element for the read port; unmatched reads give 0.
    always_comb begin
        rd_d = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (rd_addr == RW'(r*N + c))
                    rd_d = c_q[r][c];
    end

    // Controller: k innermost, then j, then i.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        complete_d = complete_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COMPUTE;
                    i_d        = '0;
                    j_d        = '0;
                    k_d        = '0;
                    complete_d = 1'b0;
                end
            end
            S_COMPUTE: begin
                if (!last_k) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (!last_j) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (!last_i) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d    = S_IDLE;
                complete_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            complete_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            complete_q <= complete_d;
            wr_err_q   <= wr_err_d;
            rd_q       <= rd_d;
        end
    end

    // Operand and result storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < K; c++)
                    a_q[r][c] <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < N; c++)
                    b_q[r][c] <= '0;
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    c_q[r][c] <= '0;
        end else begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < K; c++)
                    if (a_we && wr_addr == AW'(r*K + c))
                        a_q[r][c] <= wr_data;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < N; c++)
                    if (b_we && wr_addr == AW'(r*N + c))
                        b_q[r][c] <= wr_data;
            if (c_we)
                c_q[i_q][j_q] <= mac_acc;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed and random checks of matmul_engine against a
// plain-arithmetic matrix product model.
module tb_matmul_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, wr_sel, start;
    logic [3:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [18:0] rd_data;
    logic        busy, done, complete, wr_err;

    logic        wr_en1, wr_sel1, start1;
    logic [3:0]  wr_addr1;
    logic [2:0]  rd_addr1;
    logic [7:0]  wr_data1;
    logic [18:0] rd_data1;
    logic        busy1, done1, complete1, wr_err1;

    int n_chk  = 0;
    int n_fail = 0;
    int ma [3][3];
    int mb [3][3];

    matmul_engine dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .complete(complete), .wr_err(wr_err)
    );

    matmul_engine #(.M(2), .K(4), .N(3)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_sel(wr_sel1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .start(start1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1),
        .done(done1), .complete(complete1), .wr_err(wr_err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_c(input int r, input int c);
        int s = 0;
        for (int k = 0; k < 3; k++) s += ma[r][k] * mb[k][c];
        return s % (1 << 19);
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // One write on dut, optionally with start on the same edge.
    task automatic wr(input logic sel, input int addr, input int data,
                      input logic st);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr);
        wr_data = 8'(data); start = st;
        cyc();
        wr_en = 1'b0; start = 1'b0;
        if (addr < 9) begin
            if (sel) mb[addr/3][addr%3] = data;
            else     ma[addr/3][addr%3] = data;
        end
        chk("wr_err", 32'(wr_err), 32'(addr >= 9));
    endtask

    task automatic load(input int av [9], input int bv [9]);
        for (int x = 0; x < 9; x++) wr(1'b0, x, av[x], 1'b0);
        for (int x = 0; x < 9; x++) wr(1'b1, x, bv[x], 1'b0);
    endtask

    // Called at the first negedge after the start edge.
    task automatic wait_done(input string tag, input int exp_cyc);
        int cnt = 1;
        chk({tag, "_busy"}, 32'(busy), 1);
        while (!done && cnt < 200) begin cyc(); cnt++; end
        chk({tag, "_done_cycle"}, cnt, exp_cyc);
        cyc();
        chk({tag, "_complete"}, 32'(complete), 1);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic go(input string tag);
        start = 1'b1; cyc(); start = 1'b0;
        wait_done(tag, 28);
    endtask

    task automatic check_c(input string tag);
        for (int x = 0; x < 9; x++) begin
            rd_addr = 4'(x); cyc();
            chk({tag, "_c"}, 32'(rd_data), ref_c(x/3, x%3));
        end
        rd_addr = 4'd15; cyc();
        chk({tag, "_c_oor"}, 32'(rd_data), 0);
    endtask

    initial begin
        int av [9];
        int bv [9];
        int cnt;
        int seen;

        rst = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        start = 0; rd_addr = 0;
        wr_en1 = 0; wr_sel1 = 0; wr_addr1 = 0; wr_data1 = 0;
        start1 = 0; rd_addr1 = 0;
        foreach (ma[r, c]) begin ma[r][c] = 0; mb[r][c] = 0; end
        repeat (2) cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_complete", 32'(complete), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst1_busy", 32'(busy1), 0);
        rst = 1'b0;
        cyc();
        check_c("rst");

        // Identity product
        av = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        bv = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        load(av, bv);
        go("ident");
        check_c("ident");

        // Maximum operands
        foreach (av[x]) begin av[x] = 255; bv[x] = 255; end
        load(av, bv);
        go("max");
        check_c("max");
        rd_addr = 4'd4; cyc();
        chk("max_value", 32'(rd_data), 195075);

        // Out-of-range writes are rejected and change nothing
        wr(1'b0, 9, 1, 1'b0);
        wr(1'b1, 14, 3, 1'b0);

        // Random operands; last write shares the start edge
        repeat (2) begin
            for (int x = 0; x < 9; x++)
                wr(1'b0, x, int'($urandom_range(0, 255)), 1'b0);
            for (int x = 0; x < 8; x++)
                wr(1'b1, x, int'($urandom_range(0, 255)), 1'b0);
            wr(1'b1, 8, int'($urandom_range(0, 255)), 1'b1);
            wait_done("rand", 28);
            check_c("rand");
        end

        // Start and writes while busy are ignored
        start = 1'b1; cyc(); start = 1'b0; cnt = 1;
        repeat (3) begin cyc(); cnt++; end
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
        wr_addr = 4'd0; wr_data = 8'd99;
        cyc(); cnt++;
        chk("guard_err_a", 32'(wr_err), 1);
        wr_sel = 1'b1;
        cyc(); cnt++;
        chk("guard_err_b", 32'(wr_err), 1);
        start = 1'b0; wr_en = 1'b0;
        while (!done && cnt < 200) begin cyc(); cnt++; end
        chk("guard_done_cycle", cnt, 28);

        // Back-to-back start right after done
        cyc();
        chk("b2b_complete_hi", 32'(complete), 1);
        check_c("guard");
        start = 1'b1; cyc(); start = 1'b0;
        chk("b2b_complete_lo", 32'(complete), 0);
        wait_done("b2b", 28);
        check_c("b2b");

        // Reset in the middle of a computation
        start = 1'b1; cyc(); start = 1'b0;
        repeat (9) cyc();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        cyc();
        rst = 1'b0;
        foreach (ma[r, c]) begin ma[r][c] = 0; mb[r][c] = 0; end
        seen = 0;
        repeat (40) begin cyc(); if (done) seen++; end
        chk("abort_no_done", seen, 0);
        chk("abort_complete", 32'(complete), 0);
        check_c("abort");

        // Non-square 2x4 by 4x3, all ones
        for (int x = 0; x < 20; x++) begin
            wr_en1 = 1'b1; wr_sel1 = (x >= 8);
            wr_addr1 = 4'((x >= 8) ? x - 8 : x); wr_data1 = 8'd1;
            cyc();
            chk("ns_wr_err", 32'(wr_err1), 0);
        end
        wr_en1 = 1'b0;
        start1 = 1'b1; cyc(); start1 = 1'b0; cnt = 1;
        while (!done1 && cnt < 200) begin cyc(); cnt++; end
        chk("ns_done_cycle", cnt, 25);
        cyc();
        chk("ns_complete", 32'(complete1), 1);
        for (int x = 0; x < 7; x++) begin
            rd_addr1 = 3'(x); cyc();
            chk("ns_c", 32'(rd_data1), (x < 6) ? 4 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter M, default 3, rows of A and of C.
REQ-002 SHALL have parameter K, default 3, columns of A and rows of B.
REQ-003 SHALL have parameter N, default 3, columns of B and of C.
REQ-004 SHALL have parameter DATA_W, default 8, unsigned element width of A and B.
REQ-005 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(K)+1, result element width.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  operand write strobe.
REQ-009 SHALL have port wr_sel  input  1  target matrix: 0 = A, 1 = B.
REQ-010 SHALL have port wr_addr  input  AW=$clog2(max(M*K,K*N))  row-major element index.
REQ-011 SHALL have port wr_data  input  DATA_W  operand value.
REQ-012 SHALL have port start  input  1  compute request.
REQ-013 SHALL have port rd_addr  input  $clog2(M*N)  row-major index into C.
REQ-014 SHALL have port rd_data  output  ACC_W  registered C element.
REQ-015 SHALL have port busy  output  1  high while computing.
REQ-016 SHALL have port done  output  1  one-cycle pulse at completion.
REQ-017 SHALL have port complete  output  1  level, high from completion until next accepted start.
REQ-018 SHALL have port wr_err  output  1  one-cycle pulse for a rejected write.

Function
REQ-019 SHALL implement FSM states IDLE, COMPUTE, FINISH.
REQ-020 IDLE: SHALL accept start=1 at a rising edge -> COMPUTE; clear indices i,j,k, accumulator and complete.
REQ-021 COMPUTE: SHALL perform exactly one MAC per cycle, acc += A[i][k]*B[k][j], k innermost, then j, then i.
REQ-022 On k==K-1, SHALL write C[i][j] = acc + product and clear acc in the same edge.
REQ-023 After the MAC with i==M-1, j==N-1, k==K-1, SHALL go to FINISH; COMPUTE lasts exactly M*N*K cycles.
REQ-024 FINISH: SHALL assert done for one cycle, set complete, return to IDLE; FINISH lasts one cycle.
REQ-025 busy SHALL be high exactly in COMPUTE and FINISH.
REQ-026 start while busy SHALL be ignored, with no restart and no error.
REQ-027 wr_en in IDLE with in-range wr_addr (A: <M*K, B: <K*N) SHALL write the element on that edge.
REQ-028 wr_en while busy, or with an out-of-range address, SHALL leave storage unchanged and pulse wr_err on the next cycle.
REQ-029 wr_en and start on the same IDLE edge: the write SHALL take effect and compute SHALL start on the following cycle's data (i.e. the write completes first).
REQ-030 rd_data SHALL equal C[rd_addr] one cycle after rd_addr is presented; out-of-range rd_addr SHALL return 0; reads are allowed in any state (mid-compute values are partial).
REQ-031 Arithmetic SHALL be unsigned, with products DATA_W*2 wide and the accumulator ACC_W wide; overflow SHALL wrap modulo 2^ACC_W.
REQ-032 A and B SHALL persist across computations; a second start with no writes SHALL reproduce identical C.

Reset
REQ-033 rst SHALL clear A, B and C to 0; state to IDLE; i, j, k and acc to 0; and busy, done, complete, wr_err, rd_data to 0.
REQ-034 rst asserted mid-COMPUTE SHALL abort immediately; after release, no done pulse occurs and C reads 0.

Structure
REQ-035 The FSM state encoding and index-width helper functions SHALL reside in shared package matmul_pkg.
REQ-036 The multiply-accumulate datapath SHALL be sub-module mac_unit (inputs a, b, acc_clr, en; output acc).

Verification
REQ-037 Identity test: load A=[[1,2,3],[4,5,6],[7,8,9]] and B=I, then start -> done exactly 28 cycles after the start edge; C reads 1..9 row-major.
REQ-038 Max values: A=B=all 255 -> every C element = 195075 and no wrap at the default ACC_W.
REQ-039 Busy guard: start and writes issued at cycle 5 of COMPUTE -> each write pulses wr_err, no restart occurs, and done arrives at the original cycle.
REQ-040 Reset at cycle 10 of COMPUTE -> busy=0 the same cycle, done never pulses, and all C reads return 0.
REQ-041 Back-to-back: start on the cycle after done with unchanged operands -> complete drops, then rises again with identical C.
REQ-042 Non-square M=2, K=4, N=3 with all-ones operands -> all six C elements = 4; done 25 cycles after start; rd_addr 6 reads 0.
